cameralink_axis_packer: RTL and testbench
=========================================

// Module: cameralink_axis_packer
// PURPOSE
//  Downstream stage of the CameraLink receiver. Takes the deserialized pixel bus
//  and its FVAL/LVAL/DVAL qualifiers (already in the ACLK domain) and repacks
//  them into an AXI4-Stream video stream for the VDMA: tuser = start of frame,
//  tlast = end of line. A FIFO absorbs downstream backpressure. Overflow is
//  reported in a sticky flag. Frame geometry is reported to the AXI-Lite
//  register file.
// PARAMETERS
//  DATA_WIDTH  24  pixel bits (CameraLink ports A/B/C)
//  FIFO_DEPTH  64  output FIFO entries; power of 2, >=4
//  CNT_WIDTH   16  width of the frame, line and pixel counters
// PORTS
//  ACLK           in   1           system clock, rising edge
//  ARESET         in   1           asynchronous, active-high reset
//  enable         in   1           capture enable (from control register)
//  clr_overflow   in   1           1-cycle pulse, clears overflow
//  cl_fval        in   1           frame valid
//  cl_lval        in   1           line valid
//  cl_dval        in   1           data valid
//  cl_data        in   DATA_WIDTH  pixel data
//  m_axis_tdata   out  DATA_WIDTH  stream pixel
//  m_axis_tvalid  out  1           stream valid
//  m_axis_tready  in   1           stream ready
//  m_axis_tuser   out  1           first pixel of frame
//  m_axis_tlast   out  1           last pixel of line
//  overflow       out  1           sticky: FIFO full when a write was needed
//  frame_cnt      out  CNT_WIDTH   completed frames, wraps modulo 2^CNT_WIDTH
//  lines_last     out  CNT_WIDTH   line count of last completed frame
//  pixels_last    out  CNT_WIDTH   pixel count of last line of last completed frame
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO emptied, staging register empty, state IDLE.
//    Reset asserted mid-frame discards all buffered pixels.
//  - FSM:
//    IDLE -> WAIT_FRAME when enable=1.
//    WAIT_FRAME -> ACTIVE on an FVAL rising edge (0 in previous cycle, 1 now)
//    while enable=1. A frame already in progress is never captured.
//    ACTIVE -> WAIT_FRAME on FVAL falling edge, or -> IDLE if enable=0 at that
//    edge. Clearing enable mid-frame finishes the current frame first.
//    ACTIVE -> DROP on overflow. DROP -> WAIT_FRAME (or IDLE) on FVAL falling edge.
//  - Pixel qualify: in ACTIVE, pixel valid when cl_fval & cl_lval & cl_dval.
//  - One-entry staging register holds the newest qualified pixel with its sof bit.
//    A new qualified pixel while staging is full: push staged pixel with
//    tlast=0, then load the new pixel.
//    First cycle with LVAL=0 (or FVAL=0) after a line, staging full: push staged
//    pixel with tlast=1; staging becomes empty.
//  - sof bit is set on the first qualified pixel after entering ACTIVE. A
//    1-pixel first line gives tuser=1 and tlast=1 on the same beat.
//  - FIFO write occurs in the cycle the push condition is sampled. Write->tvalid
//    latency is 1 cycle when the FIFO is empty.
//  - AXIS: tdata/tuser/tlast stay stable while tvalid=1 and tready=0. A beat
//    transfers on tvalid & tready. A simultaneous FIFO read and write when full
//    is allowed and is not an overflow.
//  - Overflow: a push needed while FIFO full (and no read that cycle):
//    beat dropped, overflow<=1, FSM->DROP, staging cleared. Beats already in
//    the FIFO still drain normally.
//    clr_overflow clears the flag. If a new overflow occurs in the same cycle,
//    set wins.
//  - Counters:
//    Line counter increments on each tlast push. Pixel counter counts pixels
//    in the current line.
//    At the ACTIVE FVAL falling edge: frame_cnt+=1; lines_last and
//    pixels_last latch the running counts; running counts clear.
//    DROP frames do not update frame_cnt, lines_last or pixels_last.
//  - DVAL gaps inside a line insert no beats. Lines with zero qualified pixels
//    produce no beats and are not counted.
// TESTING
//  1. Frame of 4 lines x 8 pixels, data = incrementing, tready=1 -> 32 beats in
//     order; tuser only on beat 0; tlast on beats 7/15/23/31; frame_cnt=1,
//     lines_last=4, pixels_last=8.
//  2. enable raised while FVAL already high -> that frame ignored; next frame
//     captured with tuser on its first pixel.
//  3. tready=0 for a 3x100-pixel frame, FIFO_DEPTH=64 -> overflow=1 after beat
//     64 is needed; exactly 64 beats drain once tready=1; frame_cnt unchanged;
//     next frame is captured normally.
//  4. Lines of 1 pixel, with DVAL toggling every other cycle inside a 6-pixel
//     line -> 1-pixel line gives tuser=tlast=1 on the first line; 6-pixel line
//     gives 6 beats; no beats for DVAL=0 cycles.
//  5. enable dropped mid-frame -> frame completes with all tlasts; FSM returns
//     to IDLE; next frame is ignored.
//  6. ARESET pulsed mid-line with 10 beats buffered -> tvalid=0 immediately;
//     counters 0; overflow 0; the next full frame streams correctly.

Source files
------------

// File: rtl/cameralink_axis_packer_if.sv
// AXI4-Stream video bus between the CameraLink packer and the VDMA.
// tuser marks the first pixel of a frame and tlast marks the last pixel of a line.
interface cameralink_axis_packer_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/cameralink_axis_packer.sv
// Repacks qualified CameraLink pixels into AXI4-Stream video through a staging register and
// an output FIFO. It also tracks overflow and frame geometry.
module cameralink_axis_packer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic                  clr_overflow,
  input  logic                  cl_fval,
  input  logic                  cl_lval,
  input  logic                  cl_dval,
  input  logic [DATA_WIDTH-1:0] cl_data,
  cameralink_axis_packer_if.master m_axis,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  lines_last,
  output logic [CNT_WIDTH-1:0]  pixels_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DROP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  fval_q;
  logic                  stg_vld_q, stg_sof_q, sof_pend_q;
  logic [DATA_WIDTH-1:0] stg_data_q;
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH+1:0] rd_word;
  logic                  overflow_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, lines_last_q, pixels_last_q;
  logic [CNT_WIDTH-1:0]  line_cnt_q, pix_cnt_q, last_pix_q;

  logic active, fval_rise, fval_fall, pix_vld, push_mid, push_last, push;
  logic fifo_empty, fifo_full, rd_en, wr_en, ovf_evt, frame_done;

  assign active     = (state_q == S_ACTIVE);
  assign fval_rise  = cl_fval & ~fval_q;
  assign fval_fall  = ~cl_fval & fval_q;
  assign pix_vld    = active & cl_fval & cl_lval & cl_dval;
  assign push_mid   = pix_vld & stg_vld_q;
  assign push_last  = active & ~(cl_fval & cl_lval) & stg_vld_q;
  assign push       = push_mid | push_last;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en      = ~fifo_empty & m_axis.tready;
  // A write into a full FIFO is fine when the head leaves in the same cycle
  assign ovf_evt    = push & fifo_full & ~rd_en;
  assign wr_en      = push & ~ovf_evt;
  assign frame_done = active & fval_fall & ~ovf_evt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_WAIT;
      S_WAIT:   if (!enable) state_d = S_IDLE;
                else if (fval_rise) state_d = S_ACTIVE;
      S_ACTIVE: if (fval_fall) state_d = enable ? S_WAIT : S_IDLE;
                else if (ovf_evt) state_d = S_DROP;
      S_DROP:   if (fval_fall) state_d = enable ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      fval_q     <= 1'b0;
      stg_vld_q  <= 1'b0;
      stg_sof_q  <= 1'b0;
      sof_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= cl_fval;
      if (ovf_evt)        stg_vld_q <= 1'b0;
      else if (pix_vld)   stg_vld_q <= 1'b1;
      else if (push_last) stg_vld_q <= 1'b0;
      if (pix_vld) stg_sof_q <= sof_pend_q;
      if (state_q == S_WAIT && state_d == S_ACTIVE) sof_pend_q <= 1'b1;
      else if (pix_vld)                             sof_pend_q <= 1'b0;
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (ovf_evt)           overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (pix_vld) stg_data_q <= cl_data;
    if (wr_en)   mem_q[wr_ptr_q[AW-1:0]] <= {stg_sof_q, push_last, stg_data_q};
  end

  // Running counts live only inside a captured frame and clear at its end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      frame_cnt_q   <= '0;
      lines_last_q  <= '0;
      pixels_last_q <= '0;
      line_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      last_pix_q    <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt_q   <= frame_cnt_q + CNT_WIDTH'(1);
        lines_last_q  <= push_last ? line_cnt_q + CNT_WIDTH'(1) : line_cnt_q;
        pixels_last_q <= push_last ? pix_cnt_q : last_pix_q;
      end
      if (!active || fval_fall) begin
        line_cnt_q <= '0;
        pix_cnt_q  <= '0;
        last_pix_q <= '0;
      end else if (push_last) begin
        line_cnt_q <= line_cnt_q + CNT_WIDTH'(1);
        last_pix_q <= pix_cnt_q;
        pix_cnt_q  <= '0;
      end else if (pix_vld) begin
        pix_cnt_q <= pix_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : rd_word[DATA_WIDTH-1:0];
  assign m_axis.tlast  = ~fifo_empty & rd_word[DATA_WIDTH];
  assign m_axis.tuser  = ~fifo_empty & rd_word[DATA_WIDTH+1];
  assign overflow      = overflow_q;
  assign frame_cnt     = frame_cnt_q;
  assign lines_last    = lines_last_q;
  assign pixels_last   = pixels_last_q;

endmodule

// File: tb/tb_cameralink_axis_packer.sv
// Bench for cameralink_axis_packer: frame-level scoreboard of expected beats and geometry,
// a table of frame shapes, hand-written corner sequences and randomized frames.
module tb_cameralink_axis_packer;
  localparam int DW = 24;
  localparam int DEPTH = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst, enable, clr, fval, lval, dval;
  logic [DW-1:0] data;
  logic overflow;
  logic [CW-1:0] frame_cnt, lines_last, pixels_last;

  cameralink_axis_packer_if #(.DATA_WIDTH(DW)) axis ();

  cameralink_axis_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .ACLK(clk), .ARESET(rst), .enable(enable), .clr_overflow(clr),
    .cl_fval(fval), .cl_lval(lval), .cl_dval(dval), .cl_data(data),
    .m_axis(axis), .overflow(overflow), .frame_cnt(frame_cnt),
    .lines_last(lines_last), .pixels_last(pixels_last));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] mon_e;
  bit rnd_ready = 1'b0;
  int m_fc = 0, m_ll = 0, m_pl = 0, m_lines = 0, m_lastpix = 0;
  bit m_cap = 1'b0, m_first = 1'b0;
  logic [DW-1:0] pix_data = '0;

  typedef struct {
    int nl; int len0; int lenn; bit gap; int exp_fc; int exp_ll; int exp_pl;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && axis.tvalid && axis.tready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {axis.tuser, axis.tlast, axis.tdata}, 64'hFFFF_FFFF);
      else begin
        mon_e = exp_q.pop_front();
        chk("beat", {axis.tuser, axis.tlast, axis.tdata}, mon_e);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      axis.tready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(input bit cap);
    fval = 1'b1; lval = 1'b0; dval = 1'b0;
    tick(); tick();
    m_cap = cap; m_first = 1'b1; m_lines = 0; m_lastpix = 0;
  endtask

  task automatic line(input int len, input bit gap);
    lval = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (gap && i > 0) begin dval = 1'b0; tick(); end
      if (rnd_ready) pix_data = DW'($urandom());
      dval = 1'b1; data = pix_data;
      if (m_cap) begin
        exp_q.push_back({m_first, (i == len - 1), pix_data});
        m_first = 1'b0;
      end
      pix_data = pix_data + 1'b1;
      tick();
    end
    if (len == 0) begin dval = 1'b0; tick(); tick(); end
    dval = 1'b0; lval = 1'b0;
    if (m_cap && len > 0) begin m_lines++; m_lastpix = len; end
    tick(); tick();
  endtask

  task automatic frame_end();
    fval = 1'b0; lval = 1'b0; dval = 1'b0;
    tick();
    if (m_cap) begin m_fc++; m_ll = m_lines; m_pl = m_lastpix; end
    m_cap = 1'b0;
    tick(); tick();
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, m_fc);
    chk({tag, "_lines_last"}, lines_last, m_ll);
    chk({tag, "_pixels_last"}, pixels_last, m_pl);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && (axis.tvalid || exp_q.size() != 0); i++) tick();
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_tvalid_idle"}, axis.tvalid, 0);
  endtask

  initial begin
    tbl[0] = '{4, 8, 8, 1'b0, 1, 4, 8};
    tbl[1] = '{2, 1, 6, 1'b1, 2, 2, 6};
    tbl[2] = '{3, 0, 5, 1'b0, 3, 2, 5};
    tbl[3] = '{1, 1, 1, 1'b0, 4, 1, 1};

    rst = 1'b1; enable = 1'b0; clr = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0;
    data = '0; axis.tready = 1'b1;
    tick(); tick();
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tdata", {axis.tuser, axis.tlast, axis.tdata}, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_counters", {frame_cnt, lines_last, pixels_last}, 0);
    rst = 1'b0;
    enable = 1'b1;
    tick(); tick();

    for (int v = 0; v < 4; v++) begin
      frame_begin(1'b1);
      for (int l = 0; l < tbl[v].nl; l++) line((l == 0) ? tbl[v].len0 : tbl[v].lenn, tbl[v].gap);
      frame_end();
      wait_drain("tbl");
      chk("tbl_frame_cnt", frame_cnt, tbl[v].exp_fc);
      chk("tbl_lines_last", lines_last, tbl[v].exp_ll);
      chk("tbl_pixels_last", pixels_last, tbl[v].exp_pl);
    end

    // enable raised while a frame is already in progress
    enable = 1'b0; tick(); tick();
    frame_begin(1'b0);
    enable = 1'b1; tick();
    line(5, 1'b0); line(5, 1'b0);
    frame_end();
    chk("late_enable_ignored", frame_cnt, m_fc);
    frame_begin(1'b1); line(3, 1'b0); line(4, 1'b0); frame_end();
    wait_drain("late_enable_next");
    check_counters("late_enable_next");

    // overflow with no downstream ready; clear asserted with the overflow keeps the flag set
    axis.tready = 1'b0;
    frame_begin(1'b0);
    lval = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dval = 1'b1; data = pix_data;
      if (i < DEPTH) exp_q.push_back({(i == 0), 1'b0, pix_data});
      clr = (i == 65);
      pix_data = pix_data + 1'b1;
      tick();
      if (i == 64) chk("ovf_not_yet", overflow, 0);
      if (i == 65) chk("ovf_set_wins", overflow, 1);
    end
    clr = 1'b0; dval = 1'b0; lval = 1'b0; tick(); tick();
    line(100, 1'b0); line(100, 1'b0);
    frame_end();
    chk("ovf_frame_cnt", frame_cnt, m_fc);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_fifo_full_count", exp_q.size(), DEPTH);
    axis.tready = 1'b1;
    wait_drain("ovf_drain");
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    frame_begin(1'b1); line(4, 1'b0); line(4, 1'b0); frame_end();
    wait_drain("ovf_next");
    check_counters("ovf_next");

    // enable dropped mid-frame: frame completes, the following one is ignored
    frame_begin(1'b1); line(4, 1'b0);
    enable = 1'b0;
    line(4, 1'b0); line(3, 1'b1); frame_end();
    wait_drain("dis_mid");
    check_counters("dis_mid");
    frame_begin(1'b0); line(5, 1'b0); frame_end();
    tick(); tick();
    chk("dis_next_ignored_tvalid", axis.tvalid, 0);
    chk("dis_next_ignored_cnt", frame_cnt, m_fc);
    enable = 1'b1; tick(); tick();

    // asynchronous reset in the middle of a buffered line
    axis.tready = 1'b0;
    frame_begin(1'b0);
    lval = 1'b1;
    for (int i = 0; i < 11; i++) begin
      dval = 1'b1; data = pix_data; pix_data = pix_data + 1'b1; tick();
    end
    chk("pre_rst_tvalid", axis.tvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", axis.tvalid, 0);
    chk("mid_rst_counters", {frame_cnt, lines_last, pixels_last}, 0);
    chk("mid_rst_overflow", overflow, 0);
    fval = 1'b0; lval = 1'b0; dval = 1'b0;
    exp_q.delete();
    m_fc = 0; m_ll = 0; m_pl = 0;
    tick();
    rst = 1'b0; axis.tready = 1'b1;
    tick(); tick();
    frame_begin(1'b1); line(8, 1'b0); line(8, 1'b0); frame_end();
    wait_drain("post_rst");
    check_counters("post_rst");

    // randomized frames with random backpressure
    rnd_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int nl;
      nl = $urandom_range(1, 5);
      frame_begin(1'b1);
      for (int l = 0; l < nl; l++) line($urandom_range(0, 12), 1'($urandom_range(0, 1)));
      frame_end();
      wait_drain("rnd");
      check_counters("rnd");
    end
    rnd_ready = 1'b0;
    tick();
    axis.tready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
